// File: rtl/stream_packer_pkg.sv
// Shared types and helpers for the stream packer.
// Handshake qualifier, clog2 and lane-mask helpers.
package stream_packer_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic hs(input logic v, input logic r);
    return v && r;
  endfunction

  // Lanes 0..i set: (2<<i)-1
  function automatic logic [31:0] lane_mask(input logic [31:0] i);
    return (32'd2 << i) - 32'd1;
  endfunction

endpackage

// File: rtl/stream_packer_out_reg.sv
// Output register for the packer: wide word, keep, last and valid.
// Holds contents under stall; free when empty or being drained.
module pack_out_reg #(
  parameter int OW    = 32,
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             load,
  input  logic [OW-1:0]    load_data,
  input  logic [RATIO-1:0] load_keep,
  input  logic             load_last,
  input  logic             dst_ready,
  output logic             free,
  output logic             dst_vaild,
  output logic [OW-1:0]    dst_data_out,
  output logic [RATIO-1:0] dst_keep,
  output logic             dst_last
);

  assign free = ~dst_vaild | dst_ready;

  // Load replaces the word (also on same-cycle drain); else drop valid on handshake
  always_ff @(posedge clk) begin
    if (s_rst) begin
      dst_vaild    <= 1'b0;
      dst_data_out <= '0;
      dst_keep     <= '0;
      dst_last     <= 1'b0;
    end else if (load) begin
      dst_vaild    <= 1'b1;
      dst_data_out <= load_data;
      dst_keep     <= load_keep;
      dst_last     <= load_last;
    end else if (dst_ready) begin
      dst_vaild    <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer with per-lane keep mask.
// src_ready depends only on registered state and reset.
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   s_rst,
  input  logic                   src_vaild,
  input  logic [WIDTH-1:0]       src_data_in,
  input  logic                   src_last,
  output logic                   src_ready,
  output logic                   dst_vaild,
  output logic [WIDTH*RATIO-1:0] dst_data_out,
  output logic [RATIO-1:0]       dst_keep,
  output logic                   dst_last,
  input  logic                   dst_ready,
  output logic                   busy
);

  localparam int CW = clog2(RATIO);
  localparam int OW = WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  logic [CW-1:0]    idx;
  logic [OW-1:0]    acc_data;
  logic [RATIO-1:0] acc_keep;
  logic             acc_last;
  logic             acc_full;

  logic             accept;
  logic             complete;
  logic             free;
  logic             load;
  logic [OW-1:0]    beat_data;
  logic [OW-1:0]    word_data;
  logic [RATIO-1:0] word_keep;
  logic [OW-1:0]    load_data;
  logic [RATIO-1:0] load_keep;
  logic             load_last;

  assign src_ready = ~acc_full & ~s_rst;
  assign accept    = hs(src_vaild, src_ready);
  assign complete  = accept & ((idx == LAST_IDX) | src_last);

  // Lane decoder: steer the incoming beat to lane idx
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx == CW'(k)) beat_data[k*WIDTH +: WIDTH] = src_data_in;
    end
  end

  assign word_data = acc_data | beat_data;
  assign word_keep = RATIO'(lane_mask(32'(idx)));

  assign load      = free & (acc_full | complete);
  assign load_data = acc_full ? acc_data : word_data;
  assign load_keep = acc_full ? acc_keep : word_keep;
  assign load_last = acc_full ? acc_last : src_last;

  // Accumulator: fill lanes, hold a completed word when output is stalled
  always_ff @(posedge clk) begin
    if (s_rst) begin
      idx      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      acc_full <= 1'b0;
    end else if (acc_full) begin
      if (free) begin
        acc_full <= 1'b0;
        acc_data <= '0;
        acc_keep <= '0;
        acc_last <= 1'b0;
      end
    end else if (complete) begin
      idx <= '0;
      if (free) begin
        acc_data <= '0;
        acc_keep <= '0;
        acc_last <= 1'b0;
      end else begin
        acc_data <= word_data;
        acc_keep <= word_keep;
        acc_last <= src_last;
        acc_full <= 1'b1;
      end
    end else if (accept) begin
      idx      <= idx + CW'(1);
      acc_data <= word_data;
      acc_keep <= word_keep;
    end
  end

  pack_out_reg #(
    .OW    (OW),
    .RATIO (RATIO)
  ) u_out (
    .clk          (clk),
    .s_rst        (s_rst),
    .load         (load),
    .load_data    (load_data),
    .load_keep    (load_keep),
    .load_last    (load_last),
    .dst_ready    (dst_ready),
    .free         (free),
    .dst_vaild    (dst_vaild),
    .dst_data_out (dst_data_out),
    .dst_keep     (dst_keep),
    .dst_last     (dst_last)
  );

  assign busy = (idx != '0) | acc_full | dst_vaild;

endmodule
